// File: rtl/mac_stream_ctrl_pkg.sv
// Shared types and default parameters for the multi-stream MAC job controller.
package mac_stream_ctrl_package;

    localparam int unsigned DEF_NB_SRC  = 3;
    localparam int unsigned DEF_NB_SINK = 1;
    localparam int unsigned DEF_AW      = 32;
    localparam int unsigned DEF_LENW    = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT      = 3'd2,
        COMPUTE   = 3'd3,
        UPDATE    = 3'd4,
        TERMINATE = 3'd5
    } state_ctrl_t;

endpackage

// File: rtl/mac_stream_addr_gen.sv
// Per-stream address generator: latched base plus a stride-accumulated offset.
module mac_stream_addr_gen
    import mac_stream_ctrl_package::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic          i_advance,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_stride,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] r_base;
    logic [AW-1:0] r_stride;
    logic [AW-1:0] r_offset;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base   <= '0;
            r_stride <= '0;
            r_offset <= '0;
        end else if (i_clear) begin
            r_base   <= '0;
            r_stride <= '0;
            r_offset <= '0;
        end else if (i_load) begin
            r_base   <= i_base;
            r_stride <= i_stride;
            r_offset <= '0;
        end else if (i_advance) begin
            r_offset <= r_offset + r_stride;
        end
    end

    // Modulo-2^AW sum; wrap-around is intentional.
    assign o_addr = r_base + r_offset;

endmodule

// File: rtl/mac_stream_ctrl.sv
// Job controller sequencing NB_SRC/NB_SINK streamers and one engine through nb_iter
// iterations, advancing every stream address by its own stride after each one.
module mac_stream_ctrl
    import mac_stream_ctrl_package::*;
#(
    parameter int unsigned NB_SRC  = DEF_NB_SRC,
    parameter int unsigned NB_SINK = DEF_NB_SINK,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned LENW    = DEF_LENW
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [NB_SRC-1:0]           src_en_i,
    input  logic [NB_SINK-1:0]          sink_en_i,
    input  logic [(NB_SRC+NB_SINK)*AW-1:0] base_addr_i,
    input  logic [(NB_SRC+NB_SINK)*AW-1:0] stride_i,
    input  logic [LENW-1:0]             nb_iter_i,
    input  logic [NB_SRC-1:0]           src_ready_start_i,
    input  logic [NB_SINK-1:0]          sink_ready_start_i,
    output logic [NB_SRC-1:0]           src_req_start_o,
    output logic [NB_SINK-1:0]          sink_req_start_o,
    output logic [(NB_SRC+NB_SINK)*AW-1:0] addr_o,
    output logic                        engine_start_o,
    output logic                        engine_clear_o,
    output logic                        engine_enable_o,
    input  logic                        engine_done_i,
    output logic                        done_o,
    output logic                        busy_o,
    output logic [LENW-1:0]             iter_o,
    output logic [2:0]                  state_o
);

    localparam int unsigned NB_STREAM = NB_SRC + NB_SINK;

    state_ctrl_t        r_state;
    logic [NB_SRC-1:0]  r_src_en;
    logic [NB_SINK-1:0] r_sink_en;
    logic [LENW-1:0]    r_nb_iter;
    logic [LENW-1:0]    r_iter;

    logic            w_all_ready;
    logic            w_launch;
    logic            w_load;
    logic            w_advance;
    logic [LENW-1:0] w_iter_nxt;

    // Disabled streams are treated as permanently ready.
    assign w_all_ready = (&(src_ready_start_i | ~r_src_en)) & (&(sink_ready_start_i | ~r_sink_en));
    assign w_load      = (r_state == IDLE) && start_i && !clear_i;
    assign w_advance   = (r_state == UPDATE) && !clear_i;
    assign w_iter_nxt  = r_iter + LENW'(1);
    assign w_launch    = !clear_i && w_all_ready &&
                         (((r_state == START) && (r_nb_iter != '0)) || (r_state == WAIT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_src_en  <= '0;
            r_sink_en <= '0;
            r_nb_iter <= '0;
            r_iter    <= '0;
        end else if (clear_i) begin
            r_state   <= IDLE;
            r_src_en  <= '0;
            r_sink_en <= '0;
            r_nb_iter <= '0;
            r_iter    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state   <= START;
                        r_src_en  <= src_en_i;
                        r_sink_en <= sink_en_i;
                        r_nb_iter <= nb_iter_i;
                        r_iter    <= '0;
                    end
                end
                START: begin
                    if (r_nb_iter == '0)  r_state <= TERMINATE;
                    else if (w_all_ready) r_state <= COMPUTE;
                    else                  r_state <= WAIT;
                end
                WAIT: begin
                    if (w_all_ready) r_state <= COMPUTE;
                end
                COMPUTE: begin
                    if (engine_done_i) r_state <= UPDATE;
                end
                UPDATE: begin
                    r_iter  <= w_iter_nxt;
                    r_state <= (w_iter_nxt == r_nb_iter) ? TERMINATE : WAIT;
                end
                TERMINATE: begin
                    if (w_all_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        src_req_start_o  = '0;
        sink_req_start_o = '0;
        engine_start_o   = 1'b0;
        engine_clear_o   = 1'b0;
        engine_enable_o  = 1'b0;
        done_o           = 1'b0;
        case (r_state)
            IDLE: begin
                engine_clear_o  = 1'b1;
                engine_enable_o = 1'b1;
            end
            COMPUTE, UPDATE: engine_enable_o = 1'b1;
            default: ;
        endcase
        if (w_launch) begin
            src_req_start_o  = r_src_en;
            sink_req_start_o = r_sink_en;
            engine_start_o   = 1'b1;
            engine_enable_o  = 1'b1;
            engine_clear_o   = 1'b0;
        end
        if ((r_state == TERMINATE) && w_all_ready && !clear_i) done_o = 1'b1;
    end

    assign busy_o  = (r_state != IDLE);
    assign iter_o  = r_iter;
    assign state_o = r_state;

    for (genvar k = 0; k < NB_STREAM; k++) begin : g_addr
        mac_stream_addr_gen #(
            .AW(AW)
        ) u_addr_gen (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .i_clear   (clear_i),
            .i_load    (w_load),
            .i_advance (w_advance),
            .i_base    (base_addr_i[k*AW +: AW]),
            .i_stride  (stride_i[k*AW +: AW]),
            .o_addr    (addr_o[k*AW +: AW])
        );
    end

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Directed bench for mac_stream_ctrl: table of job configurations plus stall, clear
// and asynchronous-reset sequences, with a simple fixed-latency engine model.
module tb_mac_stream_ctrl;
    import mac_stream_ctrl_package::*;

    localparam int unsigned NB_SRC  = 3;
    localparam int unsigned NB_SINK = 1;
    localparam int unsigned AW      = 32;
    localparam int unsigned LENW    = 16;
    localparam int unsigned NS      = NB_SRC + NB_SINK;
    localparam int          ENG_DLY = 5;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic                 start_i = 1'b0;
    logic [NB_SRC-1:0]    src_en_i = '0;
    logic [NB_SINK-1:0]   sink_en_i = '0;
    logic [NS*AW-1:0]     base_addr_i = '0;
    logic [NS*AW-1:0]     stride_i = '0;
    logic [LENW-1:0]      nb_iter_i = '0;
    logic [NB_SRC-1:0]    src_ready_start_i = '0;
    logic [NB_SINK-1:0]   sink_ready_start_i = '0;
    logic [NB_SRC-1:0]    src_req_start_o;
    logic [NB_SINK-1:0]   sink_req_start_o;
    logic [NS*AW-1:0]     addr_o;
    logic                 engine_start_o, engine_clear_o, engine_enable_o;
    logic                 engine_done_i = 1'b0;
    logic                 done_o, busy_o;
    logic [LENW-1:0]      iter_o;
    logic [2:0]           state_o;

    mac_stream_ctrl #(
        .NB_SRC (NB_SRC),
        .NB_SINK(NB_SINK),
        .AW     (AW),
        .LENW   (LENW)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .clear_i           (clear_i),
        .start_i           (start_i),
        .src_en_i          (src_en_i),
        .sink_en_i         (sink_en_i),
        .base_addr_i       (base_addr_i),
        .stride_i          (stride_i),
        .nb_iter_i         (nb_iter_i),
        .src_ready_start_i (src_ready_start_i),
        .sink_ready_start_i(sink_ready_start_i),
        .src_req_start_o   (src_req_start_o),
        .sink_req_start_o  (sink_req_start_o),
        .addr_o            (addr_o),
        .engine_start_o    (engine_start_o),
        .engine_clear_o    (engine_clear_o),
        .engine_enable_o   (engine_enable_o),
        .engine_done_i     (engine_done_i),
        .done_o            (done_o),
        .busy_o            (busy_o),
        .iter_o            (iter_o),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monotonic event counters, written only by the monitor below.
    int          n_launch = 0, n_sink_req = 0, n_done = 0, n_overlap = 0;
    int          n_src_req [NB_SRC];
    int          done_cyc = 0, edone_cyc = 0, eng_cnt = 0;
    int          launch_cyc [$];
    logic [AW-1:0] sink_addrs [$];

    initial for (int k = 0; k < int'(NB_SRC); k++) n_src_req[k] = 0;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (engine_start_o) begin
                n_launch++;
                launch_cyc.push_back(cyc);
            end
            for (int k = 0; k < int'(NB_SRC); k++)
                if (src_req_start_o[k]) n_src_req[k]++;
            if (sink_req_start_o[0]) begin
                n_sink_req++;
                sink_addrs.push_back(addr_o[3*AW +: AW]);
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (done_o && engine_start_o) n_overlap++;
        end
        engine_done_i = 1'b0;
        if (!rst_ni || clear_i) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    engine_done_i = 1'b1;
                    edone_cyc = cyc;
                end
            end
            if (engine_start_o) eng_cnt = ENG_DLY;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]    src_en;
        logic          src_rdy2;
        logic [15:0]   nb_iter;
        logic [31:0]   sink_base;
        logic [31:0]   sink_stride;
        int            exp_launch;
        int            exp_src2_req;
        logic [31:0]   exp_src0_final;
        logic [31:0]   exp_sink_final;
    } job_t;

    job_t jobs [4];

    int t_start, b_launch, b_src2, b_sink, b_done, b_overlap, b_addr, b_lc;

    task automatic start_job(input job_t j);
        step();
        b_launch  = n_launch;
        b_src2    = n_src_req[2];
        b_sink    = n_sink_req;
        b_done    = n_done;
        b_overlap = n_overlap;
        b_addr    = sink_addrs.size();
        b_lc      = launch_cyc.size();
        src_en_i          = j.src_en;
        sink_en_i         = 1'b1;
        base_addr_i       = {j.sink_base, 32'h300, 32'h200, 32'h100};
        stride_i          = {j.sink_stride, 32'd0, 32'd4, 32'd4};
        nb_iter_i         = j.nb_iter;
        src_ready_start_i = {j.src_rdy2, 2'b11};
        sink_ready_start_i = 1'b1;
        start_i           = 1'b1;
        t_start           = cyc;
        step();
        // Scramble config after the start cycle; the job must keep its latched copy.
        start_i     = 1'b0;
        src_en_i    = '1;
        base_addr_i = '1;
        stride_i    = {NS{32'h0000_0100}};
        nb_iter_i   = 16'hFFFF;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            sample();
            if (n_done > b_done) ok = 1;
        end
        check({name, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic run_job(input job_t j, input int idx);
        string nm;
        int fl;
        logic [31:0] ea;
        nm = $sformatf("job%0d", idx);
        start_job(j);
        wait_done(nm);
        repeat (3) step();
        check({nm, "_launch"},   64'(n_launch - b_launch), 64'(j.exp_launch));
        check({nm, "_sinkreq"},  64'(n_sink_req - b_sink), 64'(j.exp_launch));
        check({nm, "_src2req"},  64'(n_src_req[2] - b_src2), 64'(j.exp_src2_req));
        check({nm, "_ndone"},    64'(n_done - b_done), 64'd1);
        check({nm, "_overlap"},  64'(n_overlap - b_overlap), 64'd0);
        check({nm, "_iter"},     64'(iter_o), 64'(j.nb_iter));
        check({nm, "_busy"},     64'(busy_o), 64'd0);
        check({nm, "_src0addr"}, 64'(addr_o[0 +: AW]), 64'(j.exp_src0_final));
        check({nm, "_sinkaddr"}, 64'(addr_o[3*AW +: AW]), 64'(j.exp_sink_final));
        for (int i = 0; i < n_sink_req - b_sink; i++) begin
            ea = j.sink_base + 32'(i) * j.sink_stride;
            check($sformatf("%s_sinkseq%0d", nm, i), 64'(sink_addrs[b_addr + i]), 64'(ea));
        end
        if (j.nb_iter == 16'd0) begin
            check({nm, "_done_lat"}, 64'(done_cyc - t_start), 64'd2);
        end else begin
            fl = (launch_cyc.size() > b_lc) ? launch_cyc[b_lc] : -100;
            check({nm, "_first_launch"}, 64'(fl - t_start), 64'd1);
            check({nm, "_done_after_edone"}, 64'(done_cyc - edone_cyc), 64'd2);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        job_t js;
        bit   ok;

        jobs[0] = '{3'b111, 1'b1, 16'd4, 32'h0000_0400, 32'd8, 4, 4, 32'h110, 32'h420};
        jobs[1] = '{3'b011, 1'b0, 16'd2, 32'h0000_0400, 32'd8, 2, 0, 32'h108, 32'h410};
        jobs[2] = '{3'b111, 1'b1, 16'd0, 32'h0000_0400, 32'd8, 0, 0, 32'h100, 32'h400};
        jobs[3] = '{3'b111, 1'b1, 16'd2, 32'hFFFF_FFF8, 32'd8, 2, 2, 32'h108, 32'h008};

        #3;
        check("rst_state",   64'(state_o), 64'(IDLE));
        check("rst_iter",    64'(iter_o), 64'd0);
        check("rst_busy",    64'(busy_o), 64'd0);
        check("rst_eclear",  64'(engine_clear_o), 64'd1);
        check("rst_eenable", 64'(engine_enable_o), 64'd1);
        check("rst_estart",  64'(engine_start_o), 64'd0);
        check("rst_done",    64'(done_o), 64'd0);
        check("rst_addr_lo", addr_o[0 +: 64], 64'd0);
        check("rst_addr_hi", addr_o[64 +: 64], 64'd0);
        #20 rst_ni = 1'b1;

        for (int i = 0; i < 4; i++) run_job(jobs[i], i);

        // Sink not ready for 10 cycles after the first UPDATE.
        js = jobs[0];
        js.nb_iter = 16'd3;
        start_job(js);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            sample();
            if (state_o == 3'(UPDATE)) ok = 1;
        end
        check("stall_update_seen", 64'(ok), 64'd1);
        step();
        sink_ready_start_i = 1'b0;
        sample();
        check("stall_state",   64'(state_o), 64'(WAIT));
        check("stall_eenable", 64'(engine_enable_o), 64'd0);
        check("stall_estart",  64'(engine_start_o), 64'd0);
        repeat (9) step();
        sample();
        check("stall_state_end", 64'(state_o), 64'(WAIT));
        check("stall_launches",  64'(n_launch - b_launch), 64'd1);
        step();
        sink_ready_start_i = 1'b1;
        sample();
        check("stall_relaunch_estart",  64'(engine_start_o), 64'd1);
        check("stall_relaunch_sinkreq", 64'(sink_req_start_o), 64'd1);
        check("stall_relaunch_eenable", 64'(engine_enable_o), 64'd1);
        wait_done("stall");
        check("stall_total_launch", 64'(n_launch - b_launch), 64'd3);
        check("stall_iter", 64'(iter_o), 64'd3);

        // Clear in COMPUTE during the third iteration.
        start_job(jobs[0]);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            sample();
            if (state_o == 3'(COMPUTE) && iter_o == 16'd2) ok = 1;
        end
        check("clr_compute_seen", 64'(ok), 64'd1);
        step();
        clear_i = 1'b1;
        sample();
        check("clr_no_done", 64'(done_o), 64'd0);
        step();
        clear_i = 1'b0;
        sample();
        check("clr_state",   64'(state_o), 64'(IDLE));
        check("clr_iter",    64'(iter_o), 64'd0);
        check("clr_busy",    64'(busy_o), 64'd0);
        check("clr_eclear",  64'(engine_clear_o), 64'd1);
        check("clr_addr_lo", addr_o[0 +: 64], 64'd0);
        check("clr_addr_hi", addr_o[64 +: 64], 64'd0);
        repeat (5) step();
        check("clr_ndone", 64'(n_done - b_done), 64'd0);
        run_job(jobs[0], 4);

        // Asynchronous reset mid-job, away from any clock edge.
        start_job(jobs[0]);
        repeat (12) step();
        check("prerst_state", 64'(state_o), 64'(COMPUTE));
        check("prerst_iter",  64'(iter_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_state",   64'(state_o), 64'(IDLE));
        check("arst_iter",    64'(iter_o), 64'd0);
        check("arst_busy",    64'(busy_o), 64'd0);
        check("arst_eclear",  64'(engine_clear_o), 64'd1);
        check("arst_eenable", 64'(engine_enable_o), 64'd1);
        check("arst_estart",  64'(engine_start_o), 64'd0);
        check("arst_srcreq",  64'(src_req_start_o), 64'd0);
        check("arst_addr_lo", addr_o[0 +: 64], 64'd0);
        check("arst_addr_hi", addr_o[64 +: 64], 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) step();
        check("postrst_state", 64'(state_o), 64'(IDLE));
        check("total_overlap", 64'(n_overlap), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
